// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one slow_memory port between the I-side and D-side L2 caches.
// Define ARB_ROUND_ROBIN_EN to alternate simultaneous requests; otherwise the D-side always wins ties.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t state;
    logic   gnt;
    logic   last;
    logic   req_i;
    logic   req_d;
    logic   pick_d;

    assign req_i = i_read | i_write;
    assign req_d = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie the port goes to whichever side was not served last.
    assign pick_d = req_d & (~req_i | ~last);
`else
    logic unused_last;
    assign pick_d      = req_d;
    assign unused_last = last;
`endif

    // A write wins over a simultaneous read from the same side, so the read is dropped.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_i | req_d) begin
                        gnt   <= pick_d;
                        state <= BUSY;
                        if (pick_d) begin
                            mem_write <= d_write;
                            mem_read  <= d_read & ~d_write;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_write <= i_write;
                            mem_read  <= i_read & ~i_write;
                            mem_addr  <= i_addr;
                            mem_wdata <= i_wdata;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RESP;
                        if (gnt) begin
                            d_rdata <= mem_rdata;
                            d_ready <= 1'b1;
                        end else begin
                            i_rdata <= mem_rdata;
                            i_ready <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    last    <= gnt;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          proc_reset;
    logic          i_read, i_write, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, mem_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic          use_fixed   = 1'b1;
    logic [DW-1:0] fixed_line  = '0;
    logic          extra_ready = 1'b0;
    int            mem_cnt     = 0;

    typedef struct {
        logic          side_d;
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] line;
        logic          exp_mr;
        logic          exp_mw;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .proc_reset(proc_reset),
        .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_ready(i_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    function automatic logic [DW-1:0] line_hash(logic [AW-1:0] a);
        return {4{a, 4'h5}} ^ 128'h0123456789ABCDEF_FEDCBA9876543210;
    endfunction

    // Slow memory: completes an access on the 4th falling edge after mem_read/mem_write rises.
    always @(negedge clk) begin
        if (mem_read | mem_write) begin
            mem_cnt   = mem_cnt + 1;
            mem_ready = (mem_cnt == 4);
        end else begin
            mem_cnt   = 0;
            mem_ready = extra_ready;
        end
        mem_rdata = use_fixed ? fixed_line : line_hash(mem_addr);
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic do_reset(input int n);
        proc_reset = 1'b1;
        clear_inputs();
        repeat (n) tick();
        proc_reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_mem_read"}, 128'(mem_read), 128'(0));
        check_output({tag, "_mem_write"}, 128'(mem_write), 128'(0));
        check_output({tag, "_mem_addr"}, 128'(mem_addr), 128'(0));
        check_output({tag, "_mem_wdata"}, mem_wdata, '0);
        check_output({tag, "_i_ready"}, 128'(i_ready), 128'(0));
        check_output({tag, "_d_ready"}, 128'(d_ready), 128'(0));
        check_output({tag, "_i_rdata"}, i_rdata, '0);
        check_output({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    task automatic wait_ready(input logic side_d, input string tag);
        logic found;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if ((side_d ? d_ready : i_ready) === 1'b1) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check_output({tag, "_ready_seen"}, 128'(found), 128'(1));
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.side_d) begin
            d_read = v.rd; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_read = v.rd; i_write = v.wr; i_addr = v.addr; i_wdata = v.wdata;
        end
        fixed_line = v.line;
        tick();
        check_output({tag, "_mem_read"}, 128'(mem_read), 128'(v.exp_mr));
        check_output({tag, "_mem_write"}, 128'(mem_write), 128'(v.exp_mw));
        check_output({tag, "_mem_addr"}, 128'(mem_addr), 128'(v.addr));
        check_output({tag, "_mem_wdata"}, mem_wdata, v.wdata);
        wait_ready(v.side_d, tag);
        check_output({tag, "_rdata"}, v.side_d ? d_rdata : i_rdata, v.exp_rdata);
        check_output({tag, "_other_ready"}, 128'(v.side_d ? i_ready : d_ready), 128'(0));
        check_output({tag, "_resp_mem_idle"}, 128'({mem_read, mem_write}), 128'(0));
        clear_inputs();
        tick();
        check_output({tag, "_ready_one_cycle"}, 128'({i_ready, d_ready}), 128'(0));
    endtask

    // Both sides request; order[] records which side each completion pulse belonged to.
    task automatic run_arb(input logic continuous, input logic exp_order [6], input string tag);
        logic i_done, d_done;
        logic order [6];
        int   got;
        i_done = 0; d_done = 0; got = 0;
        for (int k = 0; k < 6; k++) order[k] = 1'b0;
        clear_inputs();
        i_addr = 28'h100; d_addr = 28'h200;
        i_read = 1; d_read = 1;
        for (int c = 0; c < 300 && got < 6; c++) begin
            tick();
            if (i_ready) begin
                order[got] = 1'b0; got++; i_read = 0; i_done = 1;
            end else if (d_ready) begin
                order[got] = 1'b1; got++; d_read = 0; d_done = 1;
            end else if (continuous) begin
                i_read = 1; d_read = 1;
            end else if (i_done && d_done) begin
                i_read = 1; d_read = 1; i_done = 0; d_done = 0;
            end
        end
        clear_inputs();
        check_output({tag, "_grant_count"}, 128'(got), 128'(6));
        for (int k = 0; k < 6; k++)
            check_output($sformatf("%s_order%0d", tag, k), 128'(order[k]), 128'(exp_order[k]));
        do_reset(2);
    endtask

    function automatic logic decide(logic ri, logic rdq, logic last_d);
        if (ri && rdq) begin
`ifdef ARB_ROUND_ROBIN_EN
            return !last_d;
`else
            return 1'b1;
`endif
        end
        return rdq;
    endfunction

    task automatic random_run(input int cycles);
        logic          txn_open, cooling, win, model_last, i_just, d_just;
        logic          exp_mr, exp_mw, exp_ir, exp_dr;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wdata, exp_irdata, exp_drdata, pre_rdata;
        logic          pre_ready, p_ir, p_iw, p_dr, p_dw;
        logic [AW-1:0] p_ia, p_da;
        logic [DW-1:0] p_iwd, p_dwd;
        int            kind;
        txn_open = 0; cooling = 0; win = 0; model_last = 0; i_just = 0; d_just = 0;
        exp_mr = 0; exp_mw = 0; exp_addr = '0; exp_wdata = '0;
        exp_irdata = '0; exp_drdata = '0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (!(i_read | i_write) && !i_just && $urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 3);
                i_read = (kind != 1); i_write = (kind == 1 || kind == 3);
                i_addr = 28'($urandom); i_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(d_read | d_write) && !d_just && $urandom_range(0, 2) == 0) begin
                kind = $urandom_range(0, 3);
                d_read = (kind != 1); d_write = (kind == 1 || kind == 3);
                d_addr = 28'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            #1;
            pre_ready = mem_ready; pre_rdata = mem_rdata;
            p_ir = i_read; p_iw = i_write; p_ia = i_addr; p_iwd = i_wdata;
            p_dr = d_read; p_dw = d_write; p_da = d_addr; p_dwd = d_wdata;
            tick();
            exp_ir = 0; exp_dr = 0;
            if (cooling) begin
                cooling = 0;
            end else if (txn_open) begin
                if (pre_ready) begin
                    txn_open = 0; cooling = 1; model_last = win;
                    if (win) begin exp_dr = 1; exp_drdata = pre_rdata; end
                    else     begin exp_ir = 1; exp_irdata = pre_rdata; end
                end
            end else if (p_ir | p_iw | p_dr | p_dw) begin
                win       = decide(p_ir | p_iw, p_dr | p_dw, model_last);
                exp_mw    = win ? p_dw : p_iw;
                exp_mr    = (win ? p_dr : p_ir) & ~exp_mw;
                exp_addr  = win ? p_da : p_ia;
                exp_wdata = win ? p_dwd : p_iwd;
                txn_open  = 1;
            end
            check_output("rnd_mem_read", 128'(mem_read), 128'(txn_open & exp_mr));
            check_output("rnd_mem_write", 128'(mem_write), 128'(txn_open & exp_mw));
            if (txn_open) begin
                check_output("rnd_mem_addr", 128'(mem_addr), 128'(exp_addr));
                check_output("rnd_mem_wdata", mem_wdata, exp_wdata);
            end
            check_output("rnd_i_ready", 128'(i_ready), 128'(exp_ir));
            check_output("rnd_d_ready", 128'(d_ready), 128'(exp_dr));
            check_output("rnd_i_rdata", i_rdata, exp_irdata);
            check_output("rnd_d_rdata", d_rdata, exp_drdata);
            i_just = i_ready; d_just = d_ready;
            if (i_ready) begin i_read = 0; i_write = 0; end
            if (d_ready) begin d_read = 0; d_write = 0; end
        end
        clear_inputs();
    endtask

    initial begin
        logic exp_rounds [6];
        logic exp_cont [6];

        vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h0000010, 128'h0, {16{8'hA5}}, 1'b1, 1'b0, {16{8'hA5}}};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 28'h0000040, 128'h1234, 128'h0BAD, 1'b0, 1'b1, 128'h0BAD};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 128'h5, {128{1'b1}}, 1'b1, 1'b0, {128{1'b1}}};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 28'h0000123, 128'hCAFE, 128'h77, 1'b0, 1'b1, 128'h77};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 28'h0000000, {128{1'b1}}, 128'h3C, 1'b0, 1'b1, 128'h3C};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 28'h0ABCDEF, 128'hBEEF, 128'h99, 1'b0, 1'b1, 128'h99};

        exp_rounds = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ARB_ROUND_ROBIN_EN
        exp_cont   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_cont   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

        proc_reset = 1'b1;
        clear_inputs();
        repeat (3) tick();
        check_all_zero("reset");
        proc_reset = 1'b0;
        tick();

        for (int v = 0; v < 6; v++) apply_stimulus(vecs[v], v);

        // Reset held for three cycles in the middle of an access.
        use_fixed = 1; fixed_line = 128'h1111;
        i_read = 1; i_addr = 28'h20;
        tick();
        tick();
        check_output("midbusy_active", 128'(mem_read), 128'(1));
        proc_reset = 1'b1;
        clear_inputs();
        repeat (3) tick();
        check_all_zero("midbusy_reset");
        proc_reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_output("post_reset_quiet", 128'({i_ready, d_ready, mem_read, mem_write}), 128'(0));
        end

        // Requester address changes while its access is in flight.
        fixed_line = 128'h2222;
        i_read = 1; i_addr = 28'h10;
        tick();
        check_output("hold_latency", 128'(mem_read), 128'(1));
        i_addr = 28'h99; i_wdata = 128'hDEAD;
        for (int c = 0; c < 20; c++) begin
            if (i_ready) break;
            check_output("hold_mem_addr", 128'(mem_addr), 128'(28'h10));
            tick();
        end
        check_output("hold_ready", 128'(i_ready), 128'(1));
        check_output("hold_rdata", i_rdata, 128'h2222);
        clear_inputs();
        tick();

        // Request withdrawn during the access still completes.
        fixed_line = 128'hFEED;
        d_read = 1; d_addr = 28'h55;
        tick();
        d_read = 0;
        wait_ready(1'b1, "drop");
        check_output("drop_rdata", d_rdata, 128'hFEED);
        tick();
        check_output("drop_i_rdata_held", i_rdata, 128'h2222);

        // Stray mem_ready while idle must not produce a completion.
        extra_ready = 1;
        tick();
        tick();
        check_output("stray_ready", 128'({i_ready, d_ready, mem_read, mem_write}), 128'(0));
        extra_ready = 0;
        tick();

        do_reset(2);
        run_arb(1'b0, exp_rounds, "arb_rounds");
        run_arb(1'b1, exp_cont, "arb_cont");

        use_fixed = 0;
        random_run(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
